// File: rtl/id_pipe_stage.sv
// Decode pipeline stage: holds one instruction, reads operands with forwarding, builds the immediate.
// Optional macro ID_WB_BYPASS_EN: same-cycle writeback data bypasses the regfile read.
module id_pipe_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         pc_in,
    input  logic [31:0]             ir_in,
    input  logic                    flush,
    input  logic                    wb_we,
    input  logic [4:0]              wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD*5-1:0]    fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    ex_is_load,
    input  logic [4:0]              ex_rd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         pc_out,
    output logic [31:0]             ir_out,
    output logic [4:0]              rs1_addr,
    output logic [4:0]              rs2_addr,
    output logic [4:0]              rd_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic [XLEN-1:0]         imm
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] rf_q [32];

    logic            hazard;
    logic            capture;
    logic [31:0]     imm32;

    assign rs1_addr = ir_q[19:15];
    assign rs2_addr = ir_q[24:20];
    assign rd_addr  = ir_q[11:7];
    assign pc_out   = pc_q;
    assign ir_out   = ir_q;

    // Load-use: the loaded value is not yet available to forward.
    assign hazard = valid_q && ex_is_load && (ex_rd != 5'd0) &&
                    ((ex_rd == rs1_addr) || (ex_rd == rs2_addr));

    assign out_valid = valid_q && !hazard;
    assign in_ready  = !valid_q || (out_ready && !hazard);
    assign capture   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (capture) begin
            valid_d = 1'b1;
            pc_d    = pc_in;
            ir_d    = ir_in;
        end else if (out_valid && out_ready) begin
            valid_d = 1'b0;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    // Priority low to high: regfile, writeback bypass, fwd[NUM_FWD-1] .. fwd[0].
    always_comb begin
        rs1_data = rf_q[rs1_addr];
        rs2_data = rf_q[rs2_addr];
`ifdef ID_WB_BYPASS_EN
        if (wb_we && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (wb_we && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
`else
`endif
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs1_addr)) begin
                rs1_data = fwd_data[i*XLEN +: XLEN];
            end
            if (fwd_valid[i] && (fwd_rd[i*5 +: 5] == rs2_addr)) begin
                rs2_data = fwd_data[i*XLEN +: XLEN];
            end
        end
        if (rs1_addr == 5'd0) begin
            rs1_data = '0;
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = '0;
        end
    end

    always_comb begin
        imm32 = 32'd0;
        unique case (ir_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            7'b0100011:
                imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011:
                imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm32 = {ir_q[31:12], 12'd0};
            7'b1101111:
                imm32 = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm32 = 32'd0;
        endcase
    end

    // Signed size cast carries ir_q[31] up to XLEN.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: scoreboard of expected decode results plus directed checks.
module tb_id_pipe_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NUM_FWD = 2;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [XLEN-1:0]         pc_in;
    logic [31:0]             ir_in;
    logic                    flush;
    logic                    wb_we;
    logic [4:0]              wb_rd;
    logic [XLEN-1:0]         wb_data;
    logic [NUM_FWD-1:0]      fwd_valid;
    logic [NUM_FWD*5-1:0]    fwd_rd;
    logic [NUM_FWD*XLEN-1:0] fwd_data;
    logic                    ex_is_load;
    logic [4:0]              ex_rd;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN-1:0]         pc_out;
    logic [31:0]             ir_out;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [4:0]              rd_addr;
    logic [XLEN-1:0]         rs1_data;
    logic [XLEN-1:0]         rs2_data;
    logic [XLEN-1:0]         imm;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    id_pipe_stage #(
        .XLEN    (XLEN),
        .NUM_FWD (NUM_FWD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .pc_in      (pc_in),
        .ir_in      (ir_in),
        .flush      (flush),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fwd_valid  (fwd_valid),
        .fwd_rd     (fwd_rd),
        .fwd_data   (fwd_data),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pc_out     (pc_out),
        .ir_out     (ir_out),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ir, input logic [4:0] rd,
                            input logic [31:0] im, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.pc  = pc;
        e.ir  = ir;
        e.rd  = rd;
        e.imm = im;
        e.rs1 = r1;
        e.rs2 = r2;
        sb_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        check_val("sb_depth", 64'(sb_q.size() > 0), 64'h1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val("pc_out", 64'(pc_out), 64'(e.pc));
            check_val("ir_out", 64'(ir_out), 64'(e.ir));
            check_val("rd_addr", 64'(rd_addr), 64'(e.rd));
            check_val("imm", 64'(imm), 64'(e.imm));
            check_val("rs1_data", 64'(rs1_data), 64'(e.rs1));
            check_val("rs2_data", 64'(rs2_data), 64'(e.rs2));
        end
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] ir);
        pc_in    = pc;
        ir_in    = ir;
        in_valid = 1'b1;
        #1;
        check_val("send_rdy", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        #1;
        check_val("drain_vld", 64'(out_valid), 64'h1);
        if (out_valid) begin
            pop_check();
        end
        step();
        out_ready = 1'b0;
        #1;
        check_val("drain_clr", 64'(out_valid), 64'h0);
    endtask

    task automatic run_one(input logic [31:0] pc, input logic [31:0] ir, input logic [4:0] rd,
                           input logic [31:0] im, input logic [31:0] r1, input logic [31:0] r2);
        push_exp(pc, ir, rd, im, r1, r2);
        send(pc, ir);
        drain();
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        pc_in      = '0;
        ir_in      = '0;
        flush      = 1'b0;
        wb_we      = 1'b0;
        wb_rd      = '0;
        wb_data    = '0;
        fwd_valid  = '0;
        fwd_rd     = '0;
        fwd_data   = '0;
        ex_is_load = 1'b0;
        ex_rd      = '0;
        out_ready  = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check_val("rst_vld", 64'(out_valid), 64'h0);
        check_val("rst_rdy", 64'(in_ready), 64'h1);
        check_val("rst_pc", 64'(pc_out), 64'h0);
        check_val("rst_imm", 64'(imm), 64'h0);
        step();
        step();
        reset = 1'b0;
        #1;
        check_val("post_rst_vld", 64'(out_valid), 64'h0);
        check_val("post_rst_rdy", 64'(in_ready), 64'h1);

        // addi x6,x5,0 : regfile x5 reads zero after reset
        push_exp(32'h100, 32'h0002_8313, 5'd6, 32'h0, 32'h0, 32'h0);
        send(32'h100, 32'h0002_8313);
        #1;
        check_val("x5_addr", 64'(rs1_addr), 64'd5);
        drain();

        // addi x1,x0,10 ; forwarding to x0 must still give zero
        push_exp(32'h104, 32'h00A0_0093, 5'd1, 32'hA, 32'h0, 32'h0);
        send(32'h104, 32'h00A0_0093);
        fwd_valid = 2'b01;
        fwd_rd    = {5'd0, 5'd0};
        fwd_data  = {32'h0, 32'h99};
        #1;
        check_val("fwd_x0", 64'(rs1_data), 64'h0);
        fwd_valid = '0;
        drain();

        // regfile: x1=5, x2=7, write to x0 dropped
        wb_we   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'h5;
        step();
        wb_rd   = 5'd2;
        wb_data = 32'h7;
        step();
        wb_rd   = 5'd0;
        wb_data = 32'hDEAD;
        step();
        wb_we   = 1'b0;

        // add x3,x1,x2 with load-use stall on x2
        push_exp(32'h108, 32'h0020_81B3, 5'd3, 32'h0, 32'h5, 32'h7);
        send(32'h108, 32'h0020_81B3);
        ex_is_load = 1'b1;
        ex_rd      = 5'd2;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        pc_in      = 32'h200;
        ir_in      = 32'h00A0_0093;
        #1;
        check_val("haz_vld", 64'(out_valid), 64'h0);
        check_val("haz_rdy", 64'(in_ready), 64'h0);
        step();
        check_val("haz_hold_ir", 64'(ir_out), 64'h0020_81B3);
        check_val("haz_hold_vld", 64'(out_valid), 64'h0);
        in_valid = 1'b0;
        ex_rd    = 5'd0;
        #1;
        check_val("haz_x0", 64'(out_valid), 64'h1);
        ex_is_load = 1'b0;
        drain();

        // addi x4,x1,-1 : forwarding priority and sign extension
        push_exp(32'h10C, 32'hFFF0_8213, 5'd4, 32'hFFFF_FFFF, 32'h5, 32'h0);
        send(32'h10C, 32'hFFF0_8213);
        fwd_valid = 2'b11;
        fwd_rd    = {5'd1, 5'd1};
        fwd_data  = {32'h22, 32'h11};
        #1;
        check_val("fwd_lo", 64'(rs1_data), 64'h11);
        fwd_valid = 2'b10;
        #1;
        check_val("fwd_hi", 64'(rs1_data), 64'h22);
        fwd_valid = '0;
        drain();

        // addi x2,x1,0 with same-cycle write of x1
        push_exp(32'h110, 32'h0000_8113, 5'd2, 32'h0, 32'h77, 32'h0);
        send(32'h110, 32'h0000_8113);
        wb_we   = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'h77;
        #1;
`ifdef ID_WB_BYPASS_EN
        check_val("wb_same", 64'(rs1_data), 64'h77);
`else
        check_val("wb_same", 64'(rs1_data), 64'h5);
`endif
        step();
        wb_we = 1'b0;
        #1;
        check_val("wb_next", 64'(rs1_data), 64'h77);
        drain();

        // immediate formats
        run_one(32'h114, 32'h0020_A423, 5'd8,  32'h8,         32'h77, 32'h7);  // sw
        run_one(32'h118, 32'hFE00_0EE3, 5'd29, 32'hFFFF_FFFC, 32'h0,  32'h0);  // beq -4
        run_one(32'h11C, 32'hFF81_2483, 5'd9,  32'hFFFF_FFF8, 32'h7,  32'h0);  // lw -8
        run_one(32'h120, 32'h0000_8067, 5'd0,  32'h0,         32'h77, 32'h0);  // jalr
        run_one(32'h124, 32'hFFFF_F017, 5'd0,  32'hFFFF_F000, 32'h0,  32'h0);  // auipc
        run_one(32'h128, 32'hFFFF_FFFF, 5'd31, 32'h0,         32'h0,  32'h0);  // bad op

        // back-to-back: lui then jal with downstream always ready
        push_exp(32'h12C, 32'h1234_52B7, 5'd5, 32'h1234_5000, 32'h0, 32'h0);
        push_exp(32'h130, 32'h0080_00EF, 5'd1, 32'h8, 32'h0, 32'h0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pc_in     = 32'h12C;
        ir_in     = 32'h1234_52B7;
        step();
        pc_in = 32'h130;
        ir_in = 32'h0080_00EF;
        #1;
        check_val("b2b_rdy", 64'(in_ready), 64'h1);
        pop_check();
        step();
        in_valid = 1'b0;
        #1;
        check_val("b2b_vld", 64'(out_valid), 64'h1);
        pop_check();
        step();
        out_ready = 1'b0;
        #1;
        check_val("b2b_clr", 64'(out_valid), 64'h0);

        // flush with simultaneous capture from empty
        in_valid = 1'b1;
        flush    = 1'b1;
        pc_in    = 32'h140;
        ir_in    = 32'h00A0_0093;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check_val("flush_cap", 64'(out_valid), 64'h0);

        // flush a held instruction; the writeback in that cycle still lands
        send(32'h144, 32'h00A0_0093);
        #1;
        check_val("flush_pre", 64'(out_valid), 64'h1);
        flush   = 1'b1;
        wb_we   = 1'b1;
        wb_rd   = 5'd10;
        wb_data = 32'hAB;
        step();
        flush = 1'b0;
        wb_we = 1'b0;
        #1;
        check_val("flush_held", 64'(out_valid), 64'h0);
        check_val("flush_rdy", 64'(in_ready), 64'h1);
        run_one(32'h148, 32'h0005_0593, 5'd11, 32'h0, 32'hAB, 32'h0);

        // reset in the middle of a stall
        send(32'h150, 32'h0020_81B3);
        ex_is_load = 1'b1;
        ex_rd      = 5'd1;
        #1;
        check_val("stall_vld", 64'(out_valid), 64'h0);
        reset    = 1'b1;
        in_valid = 1'b1;
        pc_in    = 32'h160;
        ir_in    = 32'h00A0_0093;
        #1;
        check_val("rst_stall_vld", 64'(out_valid), 64'h0);
        check_val("rst_stall_rdy", 64'(in_ready), 64'h1);
        check_val("rst_stall_ir", 64'(ir_out), 64'h0);
        step();
        check_val("rst_nocap_ir", 64'(ir_out), 64'h0);
        check_val("rst_nocap_pc", 64'(pc_out), 64'h0);
        reset      = 1'b0;
        in_valid   = 1'b0;
        ex_is_load = 1'b0;
        ex_rd      = 5'd0;
        #1;
        check_val("rst_post_vld", 64'(out_valid), 64'h0);
        run_one(32'h164, 32'h0000_8113, 5'd2, 32'h0, 32'h0, 32'h0);  // x1 cleared by reset

        check_val("sb_final", 64'(sb_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
